payload_frame_buffer: RTL
=========================

Name: payload_frame_buffer

Overview:
- Receive-side stage directly downstream of payload_detect in the 802.11b 1 Mbps DSSS chain.
- Collects payload bytes of the current PSDU into a circular byte buffer.
- Commits the frame only when the end-of-frame CRC result is good; otherwise rewinds and discards it.
- Presents committed frames to the MAC side as a ready/valid byte stream with start-of-frame and end-of-frame markers.

Parameters:
- ADDR_W, 11: buffer address width; DEPTH = 2^ADDR_W bytes.
- MAX_BYTES, 2346: largest accepted payload in bytes. Longer headers are rejected.
- CRC_TIMEOUT, 4096: clock cycles allowed in WAIT_CRC before the frame is dropped.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- pkt_len  in  16  PLCP LENGTH field in µs; sampled on pkt_header_valid_strobe
- pkt_header_valid_strobe  in  1  one-cycle pulse: header decoded, payload follows
- payload_data  in  8  payload byte
- payload_data_valid  in  1  one-cycle byte strobe
- crc_ok  in  1  frame CRC result; qualified by crc_ok_strobe
- crc_ok_strobe  in  1  one-cycle pulse: CRC result available
- out_data  out  8  committed byte
- out_sof  out  1  out_data is the first byte of a frame
- out_eof  out  1  out_data is the last byte of a frame
- out_valid  out  1  output byte valid
- out_ready  in  1  consumer accepts byte when out_valid & out_ready
- frame_ok_count  out  16  committed frames, saturating
- frame_drop_count  out  16  dropped frames (CRC fail, overflow, timeout, bad length, restart), saturating
- overflow  out  1  one-cycle pulse on the buffer-full write attempt

Behaviour:
- Reset (reset=0, async): clear pointers, FSM=IDLE, all outputs 0, counters 0, out_sof pending flag=1.
- Storage: 9-bit entries {eof, byte}. Pointers are ADDR_W+1 bits: wr_ptr, frame_start, commit_ptr, rd_ptr.
  - full: wr_ptr - rd_ptr == DEPTH
  - empty (read side): rd_ptr == commit_ptr
- Expected length: exp_bytes = pkt_len >> 3, computed at 1 Mbps.
- FSM states and transitions:
  - IDLE: on header strobe with 1 <= exp_bytes <= MAX_BYTES, latch exp_bytes, frame_start <= wr_ptr, byte_cnt <= 0, go RECV. Otherwise increment drop count and stay in IDLE.
  - RECV: each payload_data_valid writes {byte_cnt == exp_bytes-1, byte} at wr_ptr, then wr_ptr++ and byte_cnt++. After the last byte, go WAIT_CRC.
  - RECV, write while full: pulse overflow, wr_ptr <= frame_start, drop++, go DROP.
  - WAIT_CRC: crc_ok_strobe with crc_ok=1 sets commit_ptr <= wr_ptr, ok++, go IDLE. With crc_ok=0, wr_ptr <= frame_start, drop++, go IDLE.
  - WAIT_CRC: timer reaching CRC_TIMEOUT rewinds, drop++, go IDLE. Extra payload bytes in WAIT_CRC are ignored.
  - DROP: ignore bytes. Leave to IDLE on crc_ok_strobe (no counter change), or on a header strobe, which is handled as in IDLE in the same cycle.
- Header strobe while in RECV or WAIT_CRC: rewind to frame_start, drop++, then start the new frame in the same cycle with frame_start = the rewound pointer.
- crc_ok_strobe in IDLE or RECV: ignored.
- Same-cycle events: header strobe takes priority over crc_ok_strobe and over payload_data_valid.
- Read side:
  - Output register is FWFT-style. It loads the next entry when it is empty, or when out_valid & out_ready and commit_ptr != rd_ptr.
  - Memory is synchronous read. The first committed byte appears on out_valid 2 cycles after the crc_ok_strobe edge.
  - Sustained throughput is 1 byte/cycle while out_ready=1.
  - out_sof = pending flag. The flag is set after a byte with eof is accepted and cleared after any other byte is accepted.
  - out_data, out_sof and out_eof hold stable while out_valid & !out_ready.
- Simultaneous read and write: allowed. Full is evaluated against the registered rd_ptr; a read in the same cycle does not relieve full.
- Counters saturate at 16'hFFFF.

Decomposition:
- Shared header dsss_rx_defs.vh holds:
  - FSM state encodings IDLE/RECV/WAIT_CRC/DROP
  - BYTES_PER_US_SHIFT = 3
  - MAX_PSDU_BYTES = 2346
- One sub-module, payload_buffer_ram: simple dual-port RAM, 9-bit wide, DEPTH entries.
  - Write: registered address and data.
  - Read: registered output.

Test Plan:
- Good frame: pkt_len=64, bytes 0x01..0x08, crc_ok=1 → out emits 0x01..0x08; sof on 0x01, eof on 0x08; frame_ok_count=1.
- Bad CRC: same frame with crc_ok=0 → no out_valid for 100 cycles; frame_drop_count=1. A following good 2-byte frame (0xAA, 0xBB) is emitted with correct sof/eof.
- Overflow: ADDR_W=4, out_ready=0, pkt_len=160 (20 bytes) → overflow pulses on byte 17; drop=1; the rest of the frame is ignored. A later 4-byte good frame is committed.
- Backpressure: two committed 3-byte frames, out_ready toggling 1/0 each cycle → 6 bytes in order, outputs stable while stalled, sof/eof correct on both frames.
- Restart and timeout:
  - Header strobe after 3 of 8 bytes → drop=1, and the new frame is intact.
  - A frame with no crc_ok_strobe → dropped after CRC_TIMEOUT cycles.
- Reset mid-frame: reset=0 asynchronously during RECV → all outputs 0 immediately, buffer empty. A next frame works normally. Also pkt_len=0 → drop=1, no RECV.

Source files
------------

// File: rtl/payload_frame_buffer_pkg.sv
// Shared definitions for the DSSS receive payload buffer: FSM encodings,
// rate constants and a saturating counter helper.
package payload_frame_buffer_pkg;

  // Receive FSM encodings
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RECV     = 2'd1,
    WAIT_CRC = 2'd2,
    DROP     = 2'd3
  } state_t;

  // At 1 Mbps one byte takes 8 us, so bytes = LENGTH_us >> 3
  localparam int BYTES_PER_US_SHIFT = 3;

  // Largest PSDU accepted from the PLCP header
  localparam int MAX_PSDU_BYTES = 2346;

  // Add 0..3 to a 16-bit event counter, sticking at all-ones
  function automatic logic [15:0] sat_add16(input logic [15:0] value,
                                            input logic [1:0]  inc);
    logic [16:0] sum;
    sum = {1'b0, value} + {15'd0, inc};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

endpackage

// File: rtl/payload_buffer_ram.sv
// Simple dual-port byte+flag buffer: one synchronous write port and one
// synchronous read port with a registered output.
module payload_buffer_ram #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 9
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_reg [DEPTH];
  logic [DATA_W-1:0] rd_data_reg;

  // Write port: address and data captured on the clock edge
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_reg[wr_addr] <= wr_data;
    end
  end

  // Read port: output register only updates when a read is issued
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data_reg <= mem_reg[rd_addr];
    end
  end

  assign rd_data = rd_data_reg;

endmodule

// File: rtl/payload_frame_buffer.sv
// Receive payload frame buffer: stores the bytes of the current PSDU in a
// circular buffer, commits them on a good CRC, rewinds on any failure, and
// streams committed frames out as ready/valid bytes with sof/eof markers.
module payload_frame_buffer
  import payload_frame_buffer_pkg::*;
#(
  parameter int ADDR_W      = 11,
  parameter int MAX_BYTES   = MAX_PSDU_BYTES,
  parameter int CRC_TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] pkt_len,
  input  logic        pkt_header_valid_strobe,
  input  logic [7:0]  payload_data,
  input  logic        payload_data_valid,
  input  logic        crc_ok,
  input  logic        crc_ok_strobe,
  output logic [7:0]  out_data,
  output logic        out_sof,
  output logic        out_eof,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] frame_ok_count,
  output logic [15:0] frame_drop_count,
  output logic        overflow
);

  localparam int          DEPTH        = 1 << ADDR_W;
  localparam int          PTR_W        = ADDR_W + 1;
  localparam int          CNT_W        = 16 - BYTES_PER_US_SHIFT;
  localparam logic [15:0] TIMEOUT_LAST = 16'(CRC_TIMEOUT - 1);

  // Write-side state
  state_t           state_reg;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] frame_start_reg;
  logic [PTR_W-1:0] commit_ptr_reg;
  logic [CNT_W-1:0] exp_bytes_reg;
  logic [CNT_W-1:0] byte_cnt_reg;
  logic [15:0]      timer_reg;
  logic [15:0]      ok_cnt_reg;
  logic [15:0]      drop_cnt_reg;
  logic             overflow_reg;

  // Read-side state
  logic [PTR_W-1:0] rd_ptr_reg;
  logic             rd_pend_reg;
  logic             out_valid_reg;
  logic [7:0]       out_data_reg;
  logic             out_eof_reg;
  logic             sof_pending_reg;

  // Decoded events
  logic [15:0]      exp_bytes_in;
  logic             hdr;
  logic             hdr_len_ok;
  logic             in_frame;
  logic [PTR_W-1:0] rewind_base;
  logic             full;
  logic             recv_byte;
  logic             wr_en;
  logic             wr_overflow;
  logic             last_byte;
  logic             crc_pass;
  logic             crc_fail;
  logic             wait_timeout;
  logic [1:0]       drop_inc;
  logic             load_out;
  logic             rd_issue;
  logic [8:0]       ram_rd_data;

  assign exp_bytes_in = pkt_len >> BYTES_PER_US_SHIFT;
  assign hdr          = pkt_header_valid_strobe;
  assign hdr_len_ok   = (exp_bytes_in != 16'd0) && (exp_bytes_in <= 16'(MAX_BYTES));
  assign in_frame     = (state_reg == RECV) || (state_reg == WAIT_CRC);
  // A restart discards the partial frame, so the new one begins where it began
  assign rewind_base  = in_frame ? frame_start_reg : wr_ptr_reg;
  // Full is judged against the registered read pointer only
  assign full         = (wr_ptr_reg - rd_ptr_reg) == PTR_W'(DEPTH);
  assign recv_byte    = !hdr && (state_reg == RECV) && payload_data_valid;
  assign wr_en        = recv_byte && !full;
  assign wr_overflow  = recv_byte && full;
  assign last_byte    = byte_cnt_reg == (exp_bytes_reg - CNT_W'(1));
  assign crc_pass     = !hdr && (state_reg == WAIT_CRC) && crc_ok_strobe && crc_ok;
  assign crc_fail     = !hdr && (state_reg == WAIT_CRC) && crc_ok_strobe && !crc_ok;
  assign wait_timeout = !hdr && (state_reg == WAIT_CRC) && !crc_ok_strobe &&
                        (timer_reg == TIMEOUT_LAST);

  // Number of frames dropped this cycle; a restart with a bad length drops two
  always_comb begin
    drop_inc = 2'd0;
    if (hdr) begin
      drop_inc = {1'b0, in_frame} + {1'b0, !hdr_len_ok};
    end else if (wr_overflow || crc_fail || wait_timeout) begin
      drop_inc = 2'd1;
    end
  end

  // Receive FSM: collects, commits or rewinds the current frame
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= IDLE;
      wr_ptr_reg      <= '0;
      frame_start_reg <= '0;
      commit_ptr_reg  <= '0;
      exp_bytes_reg   <= '0;
      byte_cnt_reg    <= '0;
      timer_reg       <= '0;
      ok_cnt_reg      <= '0;
      drop_cnt_reg    <= '0;
      overflow_reg    <= 1'b0;
    end else begin
      overflow_reg <= wr_overflow;
      drop_cnt_reg <= sat_add16(drop_cnt_reg, drop_inc);
      ok_cnt_reg   <= sat_add16(ok_cnt_reg, {1'b0, crc_pass});
      if (hdr) begin
        wr_ptr_reg <= rewind_base;
        timer_reg  <= '0;
        if (hdr_len_ok) begin
          exp_bytes_reg   <= exp_bytes_in[CNT_W-1:0];
          frame_start_reg <= rewind_base;
          byte_cnt_reg    <= '0;
          state_reg       <= RECV;
        end else begin
          state_reg <= IDLE;
        end
      end else begin
        case (state_reg)
          RECV: begin
            if (payload_data_valid) begin
              if (full) begin
                wr_ptr_reg <= frame_start_reg;
                state_reg  <= DROP;
              end else begin
                wr_ptr_reg   <= wr_ptr_reg + PTR_W'(1);
                byte_cnt_reg <= byte_cnt_reg + CNT_W'(1);
                if (last_byte) begin
                  timer_reg <= '0;
                  state_reg <= WAIT_CRC;
                end
              end
            end
          end
          WAIT_CRC: begin
            if (crc_ok_strobe) begin
              if (crc_ok) begin
                commit_ptr_reg <= wr_ptr_reg;
              end else begin
                wr_ptr_reg <= frame_start_reg;
              end
              state_reg <= IDLE;
            end else if (wait_timeout) begin
              wr_ptr_reg <= frame_start_reg;
              state_reg  <= IDLE;
            end else begin
              timer_reg <= timer_reg + 16'd1;
            end
          end
          DROP: begin
            if (crc_ok_strobe) begin
              state_reg <= IDLE;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  // The output register takes the RAM word whenever it is empty or being
  // consumed; a new read is issued whenever the RAM output word will be free
  assign load_out = rd_pend_reg && (!out_valid_reg || out_ready);
  assign rd_issue = (rd_ptr_reg != commit_ptr_reg) && (!rd_pend_reg || load_out);

  payload_buffer_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (9)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_reg[ADDR_W-1:0]),
    .wr_data ({last_byte, payload_data}),
    .rd_en   (rd_issue),
    .rd_addr (rd_ptr_reg[ADDR_W-1:0]),
    .rd_data (ram_rd_data)
  );

  // Read pipeline: RAM output word, then FWFT output register and sof tracking
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_reg      <= '0;
      rd_pend_reg     <= 1'b0;
      out_valid_reg   <= 1'b0;
      out_data_reg    <= '0;
      out_eof_reg     <= 1'b0;
      sof_pending_reg <= 1'b1;
    end else begin
      if (rd_issue) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      rd_pend_reg <= rd_issue || (rd_pend_reg && !load_out);
      if (load_out) begin
        out_valid_reg <= 1'b1;
        out_data_reg  <= ram_rd_data[7:0];
        out_eof_reg   <= ram_rd_data[8];
      end else if (out_ready) begin
        out_valid_reg <= 1'b0;
      end
      if (out_valid_reg && out_ready) begin
        sof_pending_reg <= out_eof_reg;
      end
    end
  end

  assign out_data         = out_data_reg;
  assign out_sof          = out_valid_reg && sof_pending_reg;
  assign out_eof          = out_eof_reg;
  assign out_valid        = out_valid_reg;
  assign frame_ok_count   = ok_cnt_reg;
  assign frame_drop_count = drop_cnt_reg;
  assign overflow         = overflow_reg;

endmodule
